// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

  // Serializer states: one start bit, eight data bits LSB first, one stop bit.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Word index inside the 16-byte window (addr[3:2]).
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  // STATUS bit positions; the FIFO count occupies [15:8].
  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  // A programmed divisor of 0 is treated as 1 so a bit never lasts zero cycles.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count; pushes into a full FIFO are dropped,
// pops from an empty FIFO are ignored. dout shows the head entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty are taken from the pre-edge count, so a push into a full
  // FIFO is lost even when a pop happens on the same edge.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the dmem port. q is zero whenever
// the window is not selected so it can be ORed with the RAM read data.
// Bus: a write happens on the edge where sel and the lane's we bit are high;
// a read returns data on q one cycle after addr, with no side effects.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] d,
  input  logic [3:0]  we,
  output logic [31:0] q,
  output logic        txd,
  output logic        tx_idle
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel;
  logic [1:0]    idx;
  logic          wr_txdata;
  logic          clr_ovf;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;
  logic          pop;
  logic          busy;
  logic          ovf;
  logic [15:0]   div;
  logic          en;
  logic [31:0]   rd_data;
  tx_state_t     state;
  logic [15:0]   cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          unused_bits;

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign idx       = addr[3:2];
  assign wr_txdata = sel && (idx == REG_TXDATA) && we[0];
  assign clr_ovf   = sel && (idx == REG_STATUS) && we[0] && d[3];
  assign pop       = (state == TX_IDLE) && en && !fifo_empty;
  assign busy      = (state != TX_IDLE);
  assign tx_idle   = fifo_empty && !busy;
  assign unused_bits = ^{addr[1:0], d[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .din   (d[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control registers: sticky overflow flag, baud divisor, enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      div <= DEFAULT_DIV;
      en  <= 1'b1;
    end else begin
      if (clr_ovf)                     ovf <= 1'b0;
      else if (wr_txdata && fifo_full) ovf <= 1'b1;
      if (sel && (idx == REG_BAUDDIV)) begin
        if (we[0]) div[7:0]  <= d[7:0];
        if (we[1]) div[15:8] <= d[15:8];
      end
      if (sel && (idx == REG_CTRL) && we[0]) en <= d[0];
    end
  end

  // Read mux for the selected register word.
  always_comb begin
    rd_data = '0;
    case (idx)
      REG_TXDATA: rd_data[31] = fifo_full;
      REG_STATUS: begin
        rd_data[15:8]       = 8'(fifo_count);
        rd_data[STAT_OVF]   = ovf;
        rd_data[STAT_EMPTY] = fifo_empty;
        rd_data[STAT_FULL]  = fifo_full;
        rd_data[STAT_BUSY]  = busy;
      end
      REG_BAUDDIV: rd_data[15:0] = div;
      REG_CTRL:    rd_data[0]    = en;
      default:     rd_data       = '0;
    endcase
  end

  // Registered read data, forced to zero outside the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= sel ? rd_data : 32'd0;
  end

  // Serializer: each state/bit lasts eff_div(div) cycles; cnt reloads at
  // every bit start so a divisor change applies from the next bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (pop) begin
            shreg <= fifo_dout;
            txd   <= 1'b0;
            cnt   <= eff_div(div) - 16'd1;
            state <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == '0) begin
            txd     <= shreg[0];
            bit_idx <= '0;
            cnt     <= eff_div(div) - 16'd1;
            state   <= TX_DATA;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (cnt == '0) begin
            cnt <= eff_div(div) - 16'd1;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (cnt == '0) state <= TX_IDLE;
          else           cnt   <= cnt - 16'd1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule
